// File: rtl/imm_ext_pkg.sv
// Shared types and constants for the registered immediate-extension stage.
package imm_ext_pkg;

    localparam int unsigned IMM_DATA_W    = 25;
    localparam int unsigned DEFAULT_XLEN  = 32;
    localparam int unsigned DEFAULT_TAG_W = 8;

    typedef enum logic [2:0] {
        ImmI     = 3'b000,
        ImmS     = 3'b001,
        ImmB     = 3'b010,
        ImmJ     = 3'b011,
        ImmU     = 3'b100,
        ImmSrai  = 3'b101,
        ImmShift = 3'b110,
        ImmRsvd  = 3'b111
    } imm_src_t;

    // Buffer entry at default widths; the pipe declares a width-matched copy.
    typedef struct packed {
        logic [DEFAULT_XLEN-1:0]  imm;
        logic [DEFAULT_TAG_W-1:0] tag;
        logic                     illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Upstream/downstream handshake bundle of the immediate-extension stage, plus flush.
interface imm_ext_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) ();

    logic                               flush;
    logic                               in_valid;
    logic                               in_ready;
    logic [2:0]                         in_src;
    logic [imm_ext_pkg::IMM_DATA_W-1:0] in_data;
    logic [TAG_W-1:0]                   in_tag;
    logic                               out_valid;
    logic                               out_ready;
    logic [XLEN-1:0]                    out_imm;
    logic [TAG_W-1:0]                   out_tag;
    logic                               out_illegal;

    modport slave (
        input  flush, in_valid, in_src, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport master (
        output flush, in_valid, in_src, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

endinterface

// File: rtl/imm_ext_comb.sv
// Combinational RISC-V immediate extender for instruction bits [31:7].
// Optional shift-amount legality checks are enabled by IMM_SHAMT_CHECK_EN.
module imm_ext_comb import imm_ext_pkg::*; #(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  imm_src_t              src_i,
    input  logic [IMM_DATA_W-1:0] data_i,
    output logic [XLEN-1:0]       imm_o,
    output logic                  illegal_o
);

    localparam int unsigned SHW = $clog2(XLEN);

    always_comb begin
        imm_o     = '0;
        illegal_o = 1'b0;
        unique case (src_i)
            ImmI:     imm_o = XLEN'($signed(data_i[24:13]));
            ImmS:     imm_o = XLEN'($signed({data_i[24:18], data_i[4:0]}));
            ImmB:     imm_o = XLEN'($signed({data_i[24], data_i[0], data_i[23:18],
                                             data_i[4:1], 1'b0}));
            ImmJ:     imm_o = XLEN'($signed({data_i[24], data_i[12:5], data_i[13],
                                             data_i[23:14], 1'b0}));
            ImmU:     imm_o = XLEN'($signed({data_i[24:5], 12'b0}));
            ImmSrai: begin
                imm_o = XLEN'(data_i[13 +: SHW]);
`ifdef IMM_SHAMT_CHECK_EN
                // instr[30] selects arithmetic shift; instr[25] is shamt[5] on RV32
                illegal_o = !data_i[23] || (XLEN == 32 && data_i[18]);
`endif
            end
            ImmShift: begin
                imm_o = XLEN'(data_i[13 +: SHW]);
`ifdef IMM_SHAMT_CHECK_EN
                illegal_o = data_i[23] || (XLEN == 32 && data_i[18]);
`endif
            end
            ImmRsvd:  illegal_o = 1'b1;
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer and flush.
// IMM_SHAMT_CHECK_EN (see imm_ext_comb) adds shift-amount legality checks.
module imm_ext_pipe import imm_ext_pkg::*; #(
    parameter int unsigned XLEN  = DEFAULT_XLEN,
    parameter int unsigned TAG_W = DEFAULT_TAG_W
) (
    input logic           clk,
    input logic           rst,
    imm_ext_pipe_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    entry_t          new_entry;
    logic [XLEN-1:0] ext_imm;
    logic            ext_illegal;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept, pop;

    imm_ext_comb #(
        .XLEN (XLEN)
    ) u_ext (
        .src_i     (imm_src_t'(bus.in_src)),
        .data_i    (bus.in_data),
        .imm_o     (ext_imm),
        .illegal_o (ext_illegal)
    );

    assign new_entry = '{imm: ext_imm, tag: bus.in_tag, illegal: ext_illegal};

    // Ready depends only on skid occupancy, so downstream stalls never reach upstream combinationally.
    assign bus.in_ready = !skid_valid_q;
    assign accept       = bus.in_valid && bus.in_ready;
    assign pop          = main_valid_q && bus.out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || pop) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept) begin
                    skid_d = new_entry;
                end
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = new_entry;
                end
            end
        end else if (accept) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.out_valid   = main_valid_q;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_tag     = main_q.tag;
    assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: an XLEN=32 instance under handshake stress and an
// XLEN=64 instance for wide sign-extension; expectations depend on IMM_SHAMT_CHECK_EN.
module tb_imm_ext_pipe;
    import imm_ext_pkg::*;

`ifdef IMM_SHAMT_CHECK_EN
    localparam bit Chk = 1'b1;
`else
    localparam bit Chk = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    imm_ext_pipe_if #(.XLEN(32), .TAG_W(8)) bus32 ();
    imm_ext_pipe_if #(.XLEN(64), .TAG_W(8)) bus64 ();

    imm_ext_pipe #(.XLEN(32), .TAG_W(8)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    imm_ext_pipe #(.XLEN(64), .TAG_W(8)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        ill;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the 32-bit instance: scoreboard pops plus stall-stability checks.
    logic        hold32 = 1'b0;
    logic [31:0] hold_imm;
    logic [7:0]  hold_tag;
    logic        hold_ill;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold32 = 1'b0;
        end else begin
            if (hold32) begin
                check("stable_valid", bus32.out_valid, 1);
                check("stable_imm", bus32.out_imm, hold_imm);
                check("stable_tag", bus32.out_tag, hold_tag);
                check("stable_ill", bus32.out_illegal, hold_ill);
            end
            if (bus32.out_valid && bus32.out_ready && !bus32.flush) begin
                if (q32.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out32: got tag %h, expected no output", bus32.out_tag);
                end else begin
                    e = q32.pop_front();
                    check("imm32", {32'b0, bus32.out_imm}, e.imm);
                    check("tag32", bus32.out_tag, e.tag);
                    check("ill32", bus32.out_illegal, e.ill);
                end
            end
            hold32   = bus32.out_valid && !bus32.out_ready && !bus32.flush;
            hold_imm = bus32.out_imm;
            hold_tag = bus32.out_tag;
            hold_ill = bus32.out_illegal;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus64.out_valid && bus64.out_ready) begin
            if (q64.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out64: got tag %h, expected no output", bus64.out_tag);
            end else begin
                e = q64.pop_front();
                check("imm64", bus64.out_imm, e.imm);
                check("tag64", bus64.out_tag, e.tag);
                check("ill64", bus64.out_illegal, e.ill);
            end
        end
    end

    task automatic push32(input logic [2:0] src, input logic [24:0] data, input logic [7:0] tag,
                          input logic [31:0] eimm, input logic eill);
        int n = 0;
        bus32.in_valid = 1'b1;
        bus32.in_src   = src;
        bus32.in_data  = data;
        bus32.in_tag   = tag;
        @(negedge clk);
        while (!bus32.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (bus32.in_ready) q32.push_back('{imm: {32'b0, eimm}, tag: tag, ill: eill});
        else check("accept_timeout32", bus32.in_ready, 1);
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
    endtask

    task automatic push64(input logic [2:0] src, input logic [24:0] data, input logic [7:0] tag,
                          input logic [63:0] eimm, input logic eill);
        int n = 0;
        bus64.in_valid = 1'b1;
        bus64.in_src   = src;
        bus64.in_data  = data;
        bus64.in_tag   = tag;
        @(negedge clk);
        while (!bus64.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (bus64.in_ready) q64.push_back('{imm: eimm, tag: tag, ill: eill});
        else check("accept_timeout64", bus64.in_ready, 1);
        @(posedge clk);
        #1;
        bus64.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("drain32", q32.size(), 0);
        check("drain64", q64.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle32(input string name);
        check({name, "_valid"}, bus32.out_valid, 0);
        check({name, "_ready"}, bus32.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus32.flush     = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.in_src    = '0;
        bus32.in_data   = '0;
        bus32.in_tag    = '0;
        bus32.out_ready = 1'b0;
        bus64.flush     = 1'b0;
        bus64.in_valid  = 1'b0;
        bus64.in_src    = '0;
        bus64.in_data   = '0;
        bus64.in_tag    = '0;
        bus64.out_ready = 1'b1;
        #12;
        check_idle32("rst");
        check("rst_imm", bus32.out_imm, 0);
        check("rst_tag", bus32.out_tag, 0);
        check("rst_ill", bus32.out_illegal, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Extension vectors, streaming at full rate
        bus32.out_ready = 1'b1;
        push32(ImmI, 25'h1FFE000, 8'h01, 32'hFFFFFFFF, 1'b0);
        check("latency_valid", bus32.out_valid, 1);
        check("latency_tag", bus32.out_tag, 8'h01);
        push32(ImmI,     25'h0246000, 8'h02, 32'h00000123, 1'b0);
        push32(ImmS,     25'h1FC0018, 8'h03, 32'hFFFFFFF8, 1'b0);
        push32(ImmB,     25'h1FC001D, 8'h04, 32'hFFFFFFFC, 1'b0);
        push32(ImmJ,     25'h0010000, 8'h05, 32'h00000008, 1'b0);
        push32(ImmJ,     25'h1FFFFFF, 8'h06, 32'hFFFFFFFE, 1'b0);
        push32(ImmU,     25'h02468A0, 8'h07, 32'h12345000, 1'b0);
        push32(ImmU,     25'h1000000, 8'h08, 32'h80000000, 1'b0);
        push32(ImmSrai,  25'h080E000, 8'h09, 32'h00000007, 1'b0);
        push32(ImmShift, 25'h003E000, 8'h0A, 32'h0000001F, 1'b0);
        push32(ImmShift, 25'h0046000, 8'h0B, 32'h00000003, Chk);
        push32(ImmSrai,  25'h000A000, 8'h0C, 32'h00000005, Chk);
        push32(ImmRsvd,  25'h1FFFFFF, 8'h0D, 32'h00000000, 1'b1);
        push64(ImmB,     25'h1FC001D, 8'h11, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        push64(ImmU,     25'h1000000, 8'h12, 64'hFFFFFFFF80000000, 1'b0);
        push64(ImmSrai,  25'h087E000, 8'h13, 64'h000000000000003F, 1'b0);
        push64(ImmI,     25'h1FFE000, 8'h14, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        drain();

        // Backpressure: fill both slots, hold off a third push, then release
        bus32.out_ready = 1'b0;
        push32(ImmU, 25'h0000020, 8'h21, 32'h00001000, 1'b0);
        push32(ImmU, 25'h0000040, 8'h22, 32'h00002000, 1'b0);
        check("full_ready", bus32.in_ready, 0);
        fork
            push32(ImmU, 25'h0000060, 8'h23, 32'h00003000, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("held_off_ready", bus32.in_ready, 0);
                end
                @(posedge clk);
                #1;
                bus32.out_ready = 1'b1;
            end
        join
        drain();

        // Simultaneous accept and pop with one entry stored
        bus32.out_ready = 1'b0;
        push32(ImmI, 25'h0002000, 8'h31, 32'h00000001, 1'b0);
        bus32.out_ready = 1'b1;
        push32(ImmI, 25'h0004000, 8'h32, 32'h00000002, 1'b0);
        check("pushpop_ready", bus32.in_ready, 1);
        check("pushpop_valid", bus32.out_valid, 1);
        check("pushpop_tag", bus32.out_tag, 8'h32);
        drain();

        // Flush with both slots full and a concurrent (blocked) input
        bus32.out_ready = 1'b0;
        push32(ImmI, 25'h0006000, 8'h41, 32'h00000003, 1'b0);
        push32(ImmI, 25'h0008000, 8'h42, 32'h00000004, 1'b0);
        bus32.in_valid = 1'b1;
        bus32.in_tag   = 8'h43;
        bus32.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus32.flush    = 1'b0;
        bus32.in_valid = 1'b0;
        q32.delete();
        check_idle32("flush_full");

        // Flush with one slot and an input that would otherwise be accepted
        push32(ImmI, 25'h000A000, 8'h44, 32'h00000005, 1'b0);
        bus32.in_valid = 1'b1;
        bus32.in_tag   = 8'h45;
        bus32.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus32.flush    = 1'b0;
        bus32.in_valid = 1'b0;
        q32.delete();
        check_idle32("flush_one");
        bus32.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_empty_valid", bus32.out_valid, 0);
        push32(ImmI, 25'h000C000, 8'h46, 32'h00000006, 1'b0);
        drain();

        // Asynchronous reset mid-stream
        bus32.out_ready = 1'b0;
        push32(ImmI, 25'h000E000, 8'h51, 32'h00000007, 1'b0);
        push32(ImmI, 25'h0010000, 8'h52, 32'h00000008, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_idle32("midrst");
        check("midrst_imm", bus32.out_imm, 0);
        check("midrst_tag", bus32.out_tag, 0);
        check("midrst_ill", bus32.out_illegal, 0);
        q32.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus32.out_ready = 1'b1;
        push32(ImmS, 25'h0000005, 8'h53, 32'h00000005, 1'b0);
        drain();
        check("final_valid", bus32.out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, registered immediate-extension stage for the decode side of the five-stage RISC-V pipeline.
- Accepts the instruction payload bits [31:7] plus the immediate-format selector, produces an XLEN-wide extended immediate one cycle later, and carries a sideband tag.
- Sits between IF/ID and ID/EX. Uses a valid/ready handshake with a 2-entry skid buffer, so ID/EX backpressure never creates a combinational ready path upstream.
- Supports pipeline flush.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- TAG_W, 8, width of the sideband tag carried alongside each immediate (e.g. ROB/PC tag).
- SHW, $clog2(XLEN), shift-amount width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all buffered entries this cycle
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept (registered)
- in_src  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 SRAI, 110 SLLI/SRLI, 111 reserved
- in_data  in  25  instruction bits [31:7]; in_data[k] = instr[k+7]
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  extended immediate
- out_tag  out  TAG_W  tag of the output entry
- out_illegal  out  1  entry used reserved format (or failed the optional check)

Behaviour:
- Reset (async, rst=1): both buffer slots empty; out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_illegal=0.
- Extension is combinational on the input side. The result is written into the buffer, so latency is exactly 1 cycle from an accepted input to out_valid (empty stage).
- Extension rules (s = in_data[24], replicated to XLEN):
  - I: sext(d[24:13]).
  - S: sext({d[24:18], d[4:0]}).
  - B: sext({d[24], d[0], d[23:18], d[4:1], 0}).
  - J: sext({d[24], d[12:5], d[13], d[23:14], 0}).
  - U: sext({d[24:5], 12'b0}); for XLEN=64, bits 63:32 = d[24].
  - SRAI and SLLI/SRLI: zero-extend d[13+SHW-1:13].
  - 111: out_imm=0, out_illegal=1.
- Buffer is 2 entries, a main slot and a skid slot.
  - Accept when in_valid && in_ready. Pop when out_valid && out_ready.
  - in_ready = skid slot empty, registered.
  - When the main slot is empty or popping: the new entry goes to main, or the skid entry moves to main and the new entry goes to skid.
  - When main is full and not popping: the new entry goes to skid, and in_ready drops next cycle.
  - Accept and pop in the same cycle are allowed; occupancy is unchanged.
  - Order is strict FIFO.
- Empty: out_valid=0. out_imm and out_tag hold their last values (don't-care for the checker).
- Full (2 entries): in_ready=0. in_valid is ignored; the upstream must hold its data.
- flush: on the next edge both slots empty, out_valid=0, in_ready=1. An input presented in the flush cycle is dropped. flush overrides accept and pop in the same cycle.
- Reset mid-operation: all entries lost immediately (async); outputs take their reset values.
- out_valid and its payload must remain stable while out_ready=0. This is checked.

Optional Feature:
- Macro: IMM_SHAMT_CHECK_EN.
- Defined:
  - For shift formats with XLEN=32, d[18] (instr[25]) must be 0, otherwise out_illegal=1.
  - For SRAI, d[23] (instr[30]) must be 1.
  - For SLLI/SRLI, d[23] must be 0.
  - On any check failure, out_imm is still produced normally.
- Undefined: no checks; out_illegal is asserted only for code 111.

Decomposition:
- Package imm_ext_pkg:
  - imm_src_t enum with the eight 3-bit codes.
  - Constants IMM_DATA_W=25 and the default XLEN.
  - Function-free typedef for a buffer entry struct {imm, tag, illegal}.
- Sub-module imm_ext_comb: purely combinational XLEN-parametrised extender (src, data -> imm, illegal). The top instantiates one copy on the input side, in front of the skid buffer.

Test Plan:
- I-type, XLEN=32: in_src=000, in_data[24:13]=12'hFFF, out_ready=1 -> next cycle out_valid=1, out_imm=32'hFFFFFFFF, illegal=0.
- B-type, XLEN=64: instr=32'hFE000EE3 (beq offset -4), data=instr[31:7] -> out_imm=64'hFFFFFFFFFFFFFFFC.
- Backpressure: out_ready=0, push tags 1,2 -> in_ready=0 after the second accept. Third push is held off. Raise out_ready -> tags out in order 1,2,3 with no duplicates or loss.
- Simultaneous push/pop with one entry stored: occupancy stays 1, in_ready stays 1, output advances to the new tag next cycle.
- Flush with 2 entries plus a concurrent in_valid: next cycle out_valid=0, in_ready=1; none of the three tags ever appear.
- Reserved code 111 -> out_illegal=1, out_imm=0. With IMM_SHAMT_CHECK_EN defined and XLEN=32: SLLI with instr[25]=1 -> out_illegal=1, out_imm=zero-extended d[17:13]. Assert rst mid-stream -> out_valid=0 immediately.
